wb_rr_arbiter: RTL and testbench

// - Round-robin Wishbone arbiter. Shares one Wishbone slave (spi_controller at 0x4000_0000) among NUM_MASTERS masters (simple_cpu, future DMA/debug).
// - Sits between the masters and the slave port; per-master ack/err routing, bus lock for multi-beat cycles, optional stalled-slave timeout.

---
 rtl/wb_rr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter sharing one slave among NUM_MASTERS masters
// Optional stalled-slave timeout enabled by defining WB_ARB_TIMEOUT_EN.

module wb_rr_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   input  logic [NUM_MASTERS-1:0]        m_stb_i,
   input  logic [NUM_MASTERS-1:0]        m_cyc_i,
   output logic [DATA_W-1:0]             m_data_o,
   output logic [NUM_MASTERS-1:0]        m_ack_o,
   output logic [NUM_MASTERS-1:0]        m_err_o,
   output logic [ADDR_W-1:0]             s_addr_o,
   output logic [DATA_W-1:0]             s_data_o,
   output logic                          s_we_o,
   output logic                          s_stb_o,
   output logic                          s_cyc_o,
   input  logic [DATA_W-1:0]             s_data_i,
   input  logic                          s_ack_i,
   output logic [NUM_MASTERS-1:0]        grant_o,
   output logic                          busy_o
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]       gidx_q, gidx_d;
   logic [IDX_W-1:0]       last_q, last_d;

   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;
   logic                   in_grant;
   logic                   owner_cyc;
   logic                   timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   assign in_grant  = (state_q == ST_GRANT);
   assign owner_cyc = m_cyc_i[gidx_q];

   // Round-robin search: first requester after the last owner, wrapping modulo NUM_MASTERS.
   always_comb begin
      int idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = (int'(last_q) + i) % NUM_MASTERS;
         if (!pick_found && m_cyc_i[idx]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(idx);
         end
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   // Timeout fires on the last allowed stalled strobe cycle; a same-cycle ack takes precedence.
   always_comb begin
      timeout_hit = in_grant && owner_cyc && s_stb_o && !s_ack_i &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   end

   // Stall counter: counts strobe cycles without ack, cleared by ack or by leaving GRANT.
   always_comb begin
      cnt_d = '0;
      if (in_grant && owner_cyc && s_stb_o && !s_ack_i && !timeout_hit) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Without the timeout option a stalled slave simply holds the grant.
   always_comb begin
      timeout_hit = 1'b0;
   end
`endif

   // Next-state logic: arbitrate in IDLE, hold the bus while the owner keeps cyc asserted.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d           = ST_GRANT;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               gidx_d            = pick_idx;
            end
         end
         ST_GRANT: begin
            if (!owner_cyc) begin
               state_d = ST_IDLE;
               grant_d = '0;
               last_d  = gidx_q;
            end else if (timeout_hit) begin
               state_d = ST_ABORT;
            end
         end
         ST_ABORT: begin
            if (!owner_cyc) begin
               state_d = ST_IDLE;
               grant_d = '0;
               last_d  = gidx_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers; pointer resets so master 0 wins first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= IDX_W'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
      end
   end

   // Slave-side mux from the owning master, forced to zero outside GRANT.
   always_comb begin
      s_addr_o = '0;
      s_data_o = '0;
      s_we_o   = 1'b0;
      s_stb_o  = 1'b0;
      s_cyc_o  = 1'b0;
      if (in_grant) begin
         s_addr_o = m_addr_i[gidx_q*ADDR_W +: ADDR_W];
         s_data_o = m_data_i[gidx_q*DATA_W +: DATA_W];
         s_we_o   = m_we_i[gidx_q];
         s_stb_o  = m_stb_i[gidx_q];
         s_cyc_o  = owner_cyc;
      end
   end

   // Master-side responses: ack and err go only to the owner, read data is broadcast.
   always_comb begin
      m_data_o = s_data_i;
      m_ack_o  = '0;
      m_err_o  = '0;
      if (in_grant && s_ack_i) begin
         m_ack_o = grant_q;
      end
      if (timeout_hit) begin
         m_err_o = grant_q;
      end
   end

   assign grant_o = grant_q;
   assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - directed self-checking bench for wb_rr_arbiter

module tb_wb_rr_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N*AW-1:0] m_addr_i = '0;
   logic [N*DW-1:0] m_data_i = '0;
   logic [N-1:0]    m_we_i = '0;
   logic [N-1:0]    m_stb_i = '0;
   logic [N-1:0]    m_cyc_i = '0;
   logic [DW-1:0]   m_data_o;
   logic [N-1:0]    m_ack_o;
   logic [N-1:0]    m_err_o;
   logic [AW-1:0]   s_addr_o;
   logic [DW-1:0]   s_data_o;
   logic            s_we_o;
   logic            s_stb_o;
   logic            s_cyc_o;
   logic [DW-1:0]   s_data_i = '0;
   logic            s_ack_i = 1'b0;
   logic [N-1:0]    grant_o;
   logic            busy_o;

   int checks = 0;
   int errors = 0;

   wb_rr_arbiter #(
      .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_we_i(m_we_i),
      .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
      .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
      .s_data_i(s_data_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] beat_data [3];
      beat_data[0] = 32'h11;
      beat_data[1] = 32'h22;
      beat_data[2] = 32'h33;

      // Reset state
      tick();
      check("rst_grant", grant_o, 2'b00);
      check("rst_busy",  busy_o,  1'b0);
      check("rst_scyc",  s_cyc_o, 1'b0);
      check("rst_sstb",  s_stb_o, 1'b0);
      check("rst_swe",   s_we_o,  1'b0);
      check("rst_ack",   m_ack_o, 2'b00);
      check("rst_err",   m_err_o, 2'b00);
      reset = 1'b0;

      // M0 single write, slave acks two cycles after stb
      m_addr_i[0 +: AW] = 32'h4000_0004;
      m_data_i[0 +: DW] = 32'h0000_00A5;
      m_we_i  = 2'b01;
      m_stb_i = 2'b01;
      m_cyc_i = 2'b01;
      #1;
      check("w_idle_scyc", s_cyc_o, 1'b0);
      check("w_idle_grant", grant_o, 2'b00);
      tick();
      check("w_grant", grant_o, 2'b01);
      check("w_busy", busy_o, 1'b1);
      check("w_addr", s_addr_o, 32'h4000_0004);
      check("w_data", s_data_o, 32'h0000_00A5);
      check("w_we", s_we_o, 1'b1);
      check("w_stb", s_stb_o, 1'b1);
      check("w_cyc", s_cyc_o, 1'b1);
      check("w_noack", m_ack_o, 2'b00);
      tick();
      tick();
      s_ack_i = 1'b1;
      #1;
      check("w_ack", m_ack_o, 2'b01);
      tick();
      s_ack_i = 1'b0;
      m_cyc_i = 2'b00;
      m_stb_i = 2'b00;
      m_we_i  = 2'b00;
      #1;
      check("w_ack_clr", m_ack_o, 2'b00);
      check("w_cyc_drop", s_cyc_o, 1'b0);
      tick();
      check("w_back_idle", grant_o, 2'b00);
      check("w_idle_busy", busy_o, 1'b0);

      // Stray ack while idle must be dropped
      s_ack_i = 1'b1;
      #1;
      check("stray_ack", m_ack_o, 2'b00);
      s_ack_i = 1'b0;

      // Simultaneous requests after reset: M0, dead cycle, M1, then M0 again
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_cyc_i = 2'b11;
      tick();
      check("rr_first", grant_o, 2'b01);
      m_cyc_i = 2'b10;
      tick();
      check("rr_dead", grant_o, 2'b00);
      tick();
      check("rr_second", grant_o, 2'b10);
      m_cyc_i = 2'b01;
      tick();
      check("rr_dead2", grant_o, 2'b00);
      m_cyc_i = 2'b11;
      tick();
      check("rr_third", grant_o, 2'b01);
      m_cyc_i = 2'b00;
      tick();
      tick();

      // M0 locks the bus over three read beats while M1 waits (pointer now past M0)
      m_cyc_i = 2'b10;
      tick();
      check("lk_pre_m1", grant_o, 2'b10);
      m_cyc_i = 2'b00;
      tick();
      m_cyc_i = 2'b01;
      m_stb_i = 2'b01;
      tick();
      check("lk_grant", grant_o, 2'b01);
      m_cyc_i = 2'b11;
      for (int b = 0; b < 3; b++) begin
         s_data_i = beat_data[b];
         s_ack_i  = 1'b1;
         #1;
         check("lk_ack", m_ack_o, 2'b01);
         check("lk_data", m_data_o, beat_data[b]);
         check("lk_hold", grant_o, 2'b01);
         tick();
      end
      s_ack_i = 1'b0;
      m_cyc_i = 2'b10;
      m_stb_i = 2'b00;
      tick();
      check("lk_release", grant_o, 2'b00);
      tick();
      check("lk_m1", grant_o, 2'b10);
      m_cyc_i = 2'b00;
      tick();
      tick();

      // Stalled slave: M0 strobes, slave never acks, M1 waits
      m_cyc_i = 2'b01;
      m_stb_i = 2'b01;
      tick();
      check("to_grant", grant_o, 2'b01);
      m_cyc_i = 2'b11;
`ifdef WB_ARB_TIMEOUT_EN
      for (int c = 1; c < TO; c++) begin
         check("to_noerr", m_err_o, 2'b00);
         tick();
      end
      check("to_err", m_err_o, 2'b01);
      check("to_err_noack", m_ack_o, 2'b00);
      tick();
      check("to_err_pulse", m_err_o, 2'b00);
      check("to_abort_cyc", s_cyc_o, 1'b0);
      check("to_abort_stb", s_stb_o, 1'b0);
      check("to_abort_busy", busy_o, 1'b1);
      tick();
      check("to_abort_hold", grant_o, 2'b01);
`else
      for (int c = 0; c < 120; c++) begin
         if (c % 20 == 0) begin
            check("stall_hold", grant_o, 2'b01);
            check("stall_noerr", m_err_o, 2'b00);
         end
         tick();
      end
      check("stall_cyc", s_cyc_o, 1'b1);
`endif
      m_cyc_i = 2'b10;
      m_stb_i = 2'b10;
      tick();
      check("to_idle", grant_o, 2'b00);
      tick();
      check("to_m1", grant_o, 2'b10);
      check("to_m1_cyc", s_cyc_o, 1'b1);

      // Reset mid M1 transaction
      reset = 1'b1;
      #1;
      check("mr_cyc", s_cyc_o, 1'b0);
      check("mr_stb", s_stb_o, 1'b0);
      check("mr_grant", grant_o, 2'b00);
      m_cyc_i = 2'b11;
      tick();
      reset = 1'b0;
      tick();
      check("mr_regrant", grant_o, 2'b01);
      m_cyc_i = 2'b00;
      m_stb_i = 2'b00;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
